// File: rtl/noc_pkg.sv
// Shared NoC link constants: flit layout, flit type codes and the default credit depth.
// Used by both ends of the credit-based link so sender and receiver agree on framing.
package noc_pkg;

   localparam int unsigned FLIT_W       = 20;
   localparam int unsigned TYPE_MSB     = 19;
   localparam int unsigned TYPE_LSB     = 18;
   localparam int unsigned CREDIT_DEPTH = 7;

   typedef enum logic [1:0] {
      FlitBody   = 2'b00,
      FlitHead   = 2'b01,
      FlitTail   = 2'b10,
      FlitSingle = 2'b11
   } flit_type_e;

   typedef enum logic {
      StIdle,
      StInPkt
   } frame_state_e;

   function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
      return flit_type_e'(flit[TYPE_MSB:TYPE_LSB]);
   endfunction

endpackage

// File: rtl/flit_fifo.sv
// Circular flit buffer with wrap-around pointers for arbitrary (non power-of-two) depth.
// Head is read combinationally and forced to zero while empty.
module flit_fifo
   import noc_pkg::*;
#(
   parameter int unsigned DEPTH = CREDIT_DEPTH,
   parameter int unsigned W     = FLIT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_req_i,
   output logic [W-1:0] rdata_o,
   output logic         valid_o,
   output logic         pop_o,
   output logic         drop_o,
   output logic [3:0]   count_o
);

   localparam int unsigned     PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
   localparam logic [3:0]      FullCnt = 4'(DEPTH);

   logic [W-1:0]    mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [3:0]      count_q, count_d;
   logic            valid_q, valid_d;
   logic            full, pop, push_ok;

   assign full    = (count_q == FullCnt);
   assign pop     = valid_q & pop_req_i;
   // A full FIFO still accepts a flit when the head leaves in the same cycle.
   assign push_ok = push_i & (~full | pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 4'd1;
         2'b01:   count_d = count_q - 4'd1;
         default: count_d = count_q;
      endcase
      valid_d = (count_d != 4'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = valid_q ? mem_q[rd_ptr_q] : '0;
   assign valid_o = valid_q;
   assign pop_o   = pop;
   assign drop_o  = push_i & ~push_ok;
   assign count_o = count_q;

endmodule

// File: rtl/credit_rx_port.sv
// Receive endpoint of the credit link: buffers flits, returns one credit per drained flit,
// and flags overflow and packet framing violations with sticky error bits.
module credit_rx_port
   import noc_pkg::*;
#(
   parameter int unsigned DEPTH = CREDIT_DEPTH,
   parameter int unsigned W     = FLIT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] datain,
   input  logic         in_valid,
   output logic [W-1:0] dataout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         co,
   output logic [3:0]   count,
   output logic         err_ovf,
   output logic         err_frame,
   input  logic         clr_err
);

   frame_state_e state_q, state_d;
   flit_type_e   ftype;
   logic         frame_err;
   logic         pop, drop;
   logic         co_q;
   logic         err_ovf_q, err_ovf_d;
   logic         err_frame_q, err_frame_d;

   flit_fifo #(
      .DEPTH(DEPTH),
      .W    (W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_i   (in_valid),
      .wdata_i  (datain),
      .pop_req_i(out_ready),
      .rdata_o  (dataout),
      .valid_o  (out_valid),
      .pop_o    (pop),
      .drop_o   (drop),
      .count_o  (count)
   );

   assign ftype = flit_type(datain);

   // Framing is tracked on every arriving flit, dropped or not.
   always_comb begin
      state_d   = state_q;
      frame_err = 1'b0;
      if (in_valid) begin
         unique case (state_q)
            StIdle: begin
               case (ftype)
                  FlitHead:   state_d = StInPkt;
                  FlitSingle: state_d = StIdle;
                  default:    frame_err = 1'b1;
               endcase
            end
            StInPkt: begin
               case (ftype)
                  FlitBody: state_d = StInPkt;
                  FlitTail: state_d = StIdle;
                  FlitHead: frame_err = 1'b1;
                  default: begin
                     frame_err = 1'b1;
                     state_d   = StIdle;
                  end
               endcase
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // A new error event takes priority over a simultaneous clear.
   always_comb begin
      err_ovf_d   = drop | (err_ovf_q & ~clr_err);
      err_frame_d = frame_err | (err_frame_q & ~clr_err);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         co_q        <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_frame_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         co_q        <= pop;
         err_ovf_q   <= err_ovf_d;
         err_frame_q <= err_frame_d;
      end
   end

   assign co        = co_q;
   assign err_ovf   = err_ovf_q;
   assign err_frame = err_frame_q;

endmodule
